// File: rtl/mem_bus_ctrl.sv
// Purpose: sequential bus master arbitrating fetch and data ports onto the memory request/rw/wait_ handshake.
// Latency: accept->done is 3 cycles with a zero-wait memory (1 on a range error, TIMEOUT+2 worst case on timeout).
// Backpressure: clients hold req until their done pulse; memory stalls via wait_, bounded by TIMEOUT per phase.
module mem_bus_ctrl #(
  parameter int TIMEOUT    = 15,
  parameter int ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        busy,
  output logic [15:0] addrs_bus,
  output logic        request,
  output logic        rw,
  output logic [15:0] data_bus_write,
  input  logic [15:0] data_bus_read,
  input  logic        wait_
);

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_ADDR = 17'(ADDR_LIMIT - 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, DONE} state_t;

  state_t        state_q, state_d;
  logic          src_d_q, src_d_d;       // 1 = data port owns the access
  logic          we_q, we_d;
  logic          err_flag_q, err_flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [15:0]   addrs_bus_q, addrs_bus_d;
  logic [15:0]   data_bus_write_q, data_bus_write_d;
  logic          request_q, request_d;
  logic          rw_q, rw_d;
  logic [15:0]   if_rdata_q, if_rdata_d;
  logic [15:0]   d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  // Data port wins arbitration; the fetch port never stores.
  logic [15:0] sel_addr;
  logic        sel_we;
  logic [15:0] sel_wdata;
  logic        sel_ok;
  assign sel_addr  = d_req ? d_addr : if_addr;
  assign sel_we    = d_req & d_we;
  assign sel_wdata = d_req ? d_wdata : 16'h0000;
  assign sel_ok    = ({1'b0, sel_addr} <= MAX_ADDR);
  assign cnt_inc   = cnt_q + CW'(1);

  // Next-state and next-output logic; every output is computed one edge ahead so it leaves a flop.
  always_comb begin
    state_d          = state_q;
    src_d_d          = src_d_q;
    we_d             = we_q;
    err_flag_d       = err_flag_q;
    cnt_d            = cnt_q;
    addrs_bus_d      = addrs_bus_q;
    data_bus_write_d = data_bus_write_q;
    if_rdata_d       = if_rdata_q;
    d_rdata_d        = d_rdata_q;
    request_d        = 1'b0;
    rw_d             = 1'b1;
    if_done_d        = 1'b0;
    d_done_d         = 1'b0;
    err_d            = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          src_d_d          = d_req;
          we_d             = sel_we;
          addrs_bus_d      = sel_addr;
          data_bus_write_d = sel_wdata;
          cnt_d            = '0;
          if (!sel_ok) begin
            err_flag_d = 1'b1;
            state_d    = DONE;
          end else begin
            err_flag_d = 1'b0;
            state_d    = ACCESS;
            request_d  = 1'b1;
            rw_d       = ~sel_we;
          end
        end
      end
      ACCESS: begin
        request_d = 1'b1;
        rw_d      = ~we_q;
        if (!wait_) begin
          if (!we_q) begin
            if (src_d_q) d_rdata_d = data_bus_read;
            else         if_rdata_d = data_bus_read;
          end
          state_d   = RELEASE;
          cnt_d     = '0;
          request_d = 1'b0;
          rw_d      = 1'b1;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          err_flag_d = 1'b1;
          state_d    = RELEASE;
          cnt_d      = '0;
          request_d  = 1'b0;
          rw_d       = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (wait_) begin
          state_d = DONE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DONE) begin
      if_done_d = ~src_d_d;
      d_done_d  = src_d_d;
      err_d     = err_flag_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset; reset aborts any access without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      src_d_q          <= 1'b0;
      we_q             <= 1'b0;
      err_flag_q       <= 1'b0;
      cnt_q            <= '0;
      addrs_bus_q      <= 16'h0000;
      data_bus_write_q <= 16'h0000;
      request_q        <= 1'b0;
      rw_q             <= 1'b1;
      if_rdata_q       <= 16'h0000;
      d_rdata_q        <= 16'h0000;
      if_done_q        <= 1'b0;
      d_done_q         <= 1'b0;
      err_q            <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      src_d_q          <= src_d_d;
      we_q             <= we_d;
      err_flag_q       <= err_flag_d;
      cnt_q            <= cnt_d;
      addrs_bus_q      <= addrs_bus_d;
      data_bus_write_q <= data_bus_write_d;
      request_q        <= request_d;
      rw_q             <= rw_d;
      if_rdata_q       <= if_rdata_d;
      d_rdata_q        <= d_rdata_d;
      if_done_q        <= if_done_d;
      d_done_q         <= d_done_d;
      err_q            <= err_d;
      busy_q           <= busy_d;
    end
  end

  assign addrs_bus      = addrs_bus_q;
  assign data_bus_write = data_bus_write_q;
  assign request        = request_q;
  assign rw             = rw_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign if_done        = if_done_q;
  assign d_done         = d_done_q;
  assign err            = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: byte-array memory stub with programmable ack latency,
// directed test-plan cases then random fetch/load/store traffic against a transaction-level model.
module tb_mem_bus_ctrl;
  localparam int T  = 15;
  localparam int AL = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] if_rdata, d_rdata;
  logic        if_done, d_done, err, busy;
  logic [15:0] addrs_bus, data_bus_write, data_bus_read;
  logic        request, rw, wait_;

  int n_vec = 0;
  int n_err = 0;

  // Memory stub: acknowledges after request has been high for `lat` cycles, releases at once.
  logic [7:0] mem [256];
  int         lat;
  int         hi_cnt = 0;
  assign wait_         = ~(request && (hi_cnt >= lat));
  assign data_bus_read = {mem[addrs_bus[7:0]], mem[addrs_bus[7:0] + 8'd1]};

  always @(posedge clk) begin
    hi_cnt <= request ? hi_cnt + 1 : 0;
    if (request && !rw && !wait_) begin
      mem[addrs_bus[7:0]]        = data_bus_write[15:8];
      mem[addrs_bus[7:0] + 8'd1] = data_bus_write[7:0];
    end
  end

  // Reference model state: memory image and each port's expected read register.
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_if_rdata, exp_d_rdata;

  mem_bus_ctrl #(.TIMEOUT(T), .ADDR_LIMIT(AL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
    .addrs_bus(addrs_bus), .request(request), .rw(rw),
    .data_bus_write(data_bus_write), .data_bus_read(data_bus_read), .wait_(wait_)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [15:0] a);
    return int'(a) <= AL - 2;
  endfunction

  function automatic bit exp_err(input logic [15:0] a, input int l);
    return !in_rng(a) || (l >= T);
  endfunction

  // Cycles from the IDLE cycle in which req is sampled to the cycle showing done.
  function automatic int exp_delay(input logic [15:0] a, input int l);
    if (!in_rng(a)) return 1;
    if (l >= T) return T + 2;
    return l + 3;
  endfunction

  // Runs one fetch, one data access, or both raised together; called and returns at a negedge with the DUT idle.
  task automatic run_txn(input bit use_i, input bit use_d, input bit we,
                         input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                         input int lat_i, input int lat_d);
    int         k, kd, ki;
    bit         got_i, got_d, req_seen, prev_req, d_phase;
    logic       prev_rw;
    logic [7:0] a0;
    kd = exp_delay(da, lat_d);
    ki = use_d ? kd + 1 + exp_delay(ia, lat_i) : exp_delay(ia, lat_i);
    if_req = use_i; if_addr = ia;
    d_req = use_d; d_we = we; d_addr = da; d_wdata = wd;
    lat = use_d ? lat_d : lat_i;
    d_phase = use_d;
    got_i = !use_i; got_d = !use_d;
    k = 0; req_seen = 0; prev_req = 0; prev_rw = 1'b1;
    while (!(got_i && got_d) && k < 80) begin
      @(negedge clk);
      k++;
      if (request) begin
        req_seen = 1;
        check("addr_hold", addrs_bus, d_phase ? da : ia);
        check("rw_dir", rw, d_phase ? !we : 1'b1);
        if (d_phase && we) check("wdata_hold", data_bus_write, wd);
        if (prev_req) check("rw_stable", rw, prev_rw);
      end
      prev_req = request; prev_rw = rw;
      if (d_done) begin
        if (got_d) check("d_done_spurious", d_done, 1'b0);
        else begin
          got_d = 1; d_req = 1'b0;
          check("d_done_cyc", k, kd);
          check("d_err", err, exp_err(da, lat_d));
          check("req_low_at_done", request, 1'b0);
          check("busy_at_done", busy, 1'b1);
          if (!in_rng(da)) check("range_no_req", req_seen, 1'b0);
          if (!exp_err(da, lat_d)) begin
            a0 = da[7:0];
            if (we) begin
              ref_mem[a0] = wd[15:8]; ref_mem[a0 + 8'd1] = wd[7:0];
              check("store_mem", {mem[a0], mem[a0 + 8'd1]}, wd);
            end else begin
              exp_d_rdata = {ref_mem[a0], ref_mem[a0 + 8'd1]};
            end
          end
          check("d_rdata", d_rdata, exp_d_rdata);
          check("if_rdata_kept", if_rdata, exp_if_rdata);
          d_phase = 0; lat = lat_i; req_seen = 0;
        end
      end
      if (if_done) begin
        if (got_i || !got_d) check("if_done_spurious", if_done, 1'b0);
        else begin
          got_i = 1; if_req = 1'b0;
          check("if_done_cyc", k, ki);
          check("if_err", err, exp_err(ia, lat_i));
          check("req_low_at_done", request, 1'b0);
          if (!in_rng(ia)) check("range_no_req", req_seen, 1'b0);
          if (!exp_err(ia, lat_i)) begin
            a0 = ia[7:0];
            exp_if_rdata = {ref_mem[a0], ref_mem[a0 + 8'd1]};
          end
          check("if_rdata", if_rdata, exp_if_rdata);
          check("d_rdata_kept", d_rdata, exp_d_rdata);
        end
      end
    end
    check("all_done", {got_i, got_d}, 2'b11);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("done_pulse_1cyc", {if_done, d_done, busy}, 3'b000);
  endtask

  // Reset asserted while a store is stalled in ACCESS.
  task automatic reset_mid_access();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hbeef; lat = 1000;
    repeat (3) @(negedge clk);
    check("rst_pre_req", request, 1'b1);
    check("rst_pre_busy", busy, 1'b1);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rst_req_low", request, 1'b0);
    check("rst_rw_high", rw, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_no_done", {if_done, d_done, err}, 3'b000);
    reset = 1'b0;
    exp_if_rdata = 16'h0000; exp_d_rdata = 16'h0000;
    repeat (4) begin
      @(negedge clk);
      check("rst_quiet", {if_done, d_done, busy, request}, 4'b0000);
    end
    check("rst_rdata", {if_rdata, d_rdata}, {exp_if_rdata, exp_d_rdata});
    check("rst_mem_untouched", {mem[8'h20], mem[8'h21]}, {ref_mem[8'h20], ref_mem[8'h21]});
  endtask

  logic [15:0] ra_i, ra_d;

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h00FF;
    if (r == 1) return 16'(16'h0100 + $urandom_range(0, 16'hFEFF));
    return 16'($urandom_range(0, AL - 2));
  endfunction

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    if (r == 7) return T - 1;
    if (r == 8) return T;
    return T + 5;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h00] = 8'h00; ref_mem[8'h01] = 8'h80;
    ref_mem[8'h80] = 8'hab; ref_mem[8'h81] = 8'hcd;
    for (int i = 0; i < 256; i++) mem[i] = ref_mem[i];
    exp_if_rdata = 16'h0000; exp_d_rdata = 16'h0000;
    reset = 1'b1; lat = 0;
    if_req = 1'b0; if_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_request", request, 1'b0);
    check("rst_rw", rw, 1'b1);
    check("rst_addr", addrs_bus, 16'h0000);
    check("rst_wdata", data_bus_write, 16'h0000);
    check("rst_rdata_regs", {if_rdata, d_rdata}, 32'h0);
    check("rst_flags", {if_done, d_done, err, busy}, 4'b0000);

    run_txn(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    check("fetch_value", if_rdata, 16'h0080);
    run_txn(0, 1, 0, 16'h0000, 16'h0080, 16'h0000, 0, 0);
    check("load_value", d_rdata, 16'habcd);
    run_txn(0, 1, 1, 16'h0000, 16'h0084, 16'h1234, 0, 0);
    run_txn(0, 1, 0, 16'h0000, 16'h0084, 16'h0000, 0, 0);
    check("store_load_value", d_rdata, 16'h1234);
    run_txn(1, 1, 0, 16'h0080, 16'h0000, 16'h0000, 0, 0);
    run_txn(0, 1, 0, 16'h0000, 16'h00FF, 16'h0000, 0, 0);
    run_txn(0, 1, 0, 16'h0000, 16'h0100, 16'h0000, 0, 0);
    run_txn(1, 0, 0, 16'h00FE, 16'h0000, 16'h0000, 0, 0);
    run_txn(0, 1, 0, 16'h0000, 16'h0080, 16'h0000, 1000, 1000);
    run_txn(0, 1, 1, 16'h0000, 16'h0040, 16'h5a5a, T - 1, T - 1);
    run_txn(0, 1, 1, 16'h0000, 16'h0042, 16'ha5a5, T, T);
    reset_mid_access();

    for (int n = 0; n < 80; n++) begin
      int sel;
      sel  = $urandom_range(0, 2);
      ra_i = rand_addr();
      ra_d = rand_addr();
      run_txn(sel != 1, sel != 0, 1'($urandom_range(0, 1)), ra_i, ra_d,
              16'($urandom), rand_lat(), rand_lat());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Sequential bus master between the CPU core and the 256-byte `Memory` block. It arbitrates between an instruction-fetch port and a data load/store port, and drives the memory's `request`/`rw`/`wait_` handshake. It holds address and write data stable for the whole access, captures read data, and reports completion or error to the requesting port. It sits directly upstream of the memory, and the core's fetch and execute stages are its only clients.

## Interface
- `TIMEOUT`, default 15: cycles allowed per handshake phase before error.
- `ADDR_LIMIT`, default 256: memory size in bytes. Valid word address is `addr <= ADDR_LIMIT-2`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch request, level.
- `if_addr`  in  16  fetch byte address.
- `if_rdata`  out  16  fetched word, big-endian (`mem[a]` in [15:8]).
- `if_done`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request, level.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  16  data byte address.
- `d_wdata`  in  16  store data.
- `d_rdata`  out  16  loaded word.
- `d_done`  out  1  one-cycle completion pulse for data.
- `err`  out  1  valid with `if_done`/`d_done`: range violation or timeout.
- `busy`  out  1  high whenever state != IDLE.
- `addrs_bus`  out  16  memory address.
- `request`  out  1  memory request.
- `rw`  out  1  1 = read, 0 = write.
- `data_bus_write`  out  16  memory write data.
- `data_bus_read`  in  16  memory read data.
- `wait_`  in  1  memory acknowledge, active-low.

## Operation
- **Reset:** every output is registered. Reset values are state = IDLE, `request=0`, `rw=1`, `addrs_bus=0`, `data_bus_write=0`, `if_rdata=d_rdata=0`, and done/`err`/`busy` = 0.
- **IDLE:**
  - `request=0`, `rw=1`.
  - If `d_req` is high, accept the data port. Else if `if_req` is high, accept the fetch port. Data wins on a simultaneous request.
  - On accept, latch source, addr, we and wdata, and clear the timeout counter.
  - If the address is out of range, set the error flag and go to DONE. No bus cycle is issued.
  - Otherwise go to ACCESS.
- **ACCESS:**
  - `request=1`, `rw=~we`. `addrs_bus` and `data_bus_write` hold the latched values, unchanged the whole state.
  - If `wait_==0`: on a load, capture `data_bus_read` into the source's rdata register, then go to RELEASE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set the error flag and go to RELEASE.
- **RELEASE:**
  - `request=0`, `rw=1`, driven on the same edge.
  - When `wait_==1`, go to DONE.
  - The timeout counter restarts on entry. On expiry, set the error flag and go to DONE.
- **DONE:**
  - Pulse `if_done` or `d_done` for the latched source, and drive `err` with the error flag, for one cycle.
  - Go to IDLE.
- **Client rule:** hold req until done is seen, and drop it in the done cycle. A req still high in the following IDLE cycle starts a new access.
- **rdata on error:** rdata is not updated on an errored load. It is not updated on any store.
- `rw` never changes while `request` is high.
- **Reset mid-operation:** return to IDLE, `request=0` on the next edge, no done pulse. Memory contents may hold a partial store.

## Timing
- Zero-wait memory (`wait_` responds combinationally), request accepted at edge N:
  - `request` high during N..N+1.
  - RELEASE during N+1..N+2.
  - done high during N+2..N+3.
- Throughput is one access per 4 cycles including IDLE.
- Range error: done and `err` come one cycle after acceptance, and `request` stays low.
- Timeout: `err` with done comes `TIMEOUT`+2 cycles after acceptance, worst case per phase.
- The read value is captured at the edge leaving ACCESS. It is visible on rdata from the RELEASE cycle onward and is stable at done.

## Test plan
- **Fetch:** `if_addr=0x0000` with memory preloaded `mem[0]=00`, `mem[1]=80` -> `if_done` 3 cycles after accept, `if_rdata=0x0080`, `err=0`.
- **Load:** `d_addr=0x0080` with `mem[0x80]=ab`, `mem[0x81]=cd` -> `d_rdata=0xabcd`, `d_done` pulse of exactly 1 cycle.
- **Store then load:** store `0x1234` to `0x0084`, then load `0x0084` -> `mem[0x84]=12`, `mem[0x85]=34`, `d_rdata=0x1234`; `rw` never toggles while `request=1`.
- **Contention:** `if_req` and `d_req` raised on the same cycle -> `d_done` first, `if_done` 4 cycles later, both with correct data.
- **Range error:** `d_addr=0x00FF`, then `0x0100` -> each gives `err=1` with `d_done` 1 cycle after accept, `request` never high, `d_rdata` unchanged.
- **Timeout and reset:**
  - Memory stub holds `wait_=1` -> `err` with done after `TIMEOUT`+2 cycles, `request` low at done.
  - Repeat with `reset` asserted mid-ACCESS -> `request=0` next edge, no done, `busy=0`.
